encode_ctrl: RTL and testbench
==============================

ENCODE_CTRL -- requirements
Module: encode_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: feature-count, threshold and encoder counter width.
REQ-002 SHALL have parameter DIM, default `DIM: hypervector width.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have start input 1: request one encode of cfg_n feature vectors.
REQ-005 SHALL have abort input 1: synchronous return to IDLE.
REQ-006 SHALL have cfg_n input CNT_W (feature count) and cfg_thre input CNT_W (threshold), both sampled on an accepted start.
REQ-007 SHALL have feat_valid input 1, feat_ready output 1 and feat_data input DIM: feature stream.
REQ-008 SHALL have enc_clr output 1, enc_en output 1, enc_cnt output CNT_W, enc_thre output CNT_W and enc_data output DIM: encoder drive.
REQ-009 SHALL have enc_vec input DIM (encoder result) and enc_done input 1 (encoder count carry).
REQ-010 SHALL have out_valid output 1, out_ready input 1 and out_data output DIM: result stream.
REQ-011 SHALL have busy output 1, cfg_err output 1 (sticky), sync_err output 1 (sticky) and n_done output 16 (completed-encode count).

Function
REQ-012 SHALL implement states IDLE, CLR, ACC, CAPT, OUT.
REQ-013 IDLE: start=1 and cfg_n!=0 SHALL latch cfg_n/cfg_thre into n_reg/thre_reg, clear cfg_err and sync_err, and go to CLR next cycle.
REQ-014 IDLE: start=1 and cfg_n==0 SHALL set cfg_err and stay IDLE; start outside IDLE SHALL be ignored.
REQ-015 CLR: enc_clr=1 for exactly one cycle, feature counter k cleared to 0, then go to ACC.
REQ-016 ACC: feat_ready=1; a feature is accepted on a cycle with feat_valid&feat_ready; enc_en SHALL equal that accept term combinationally; enc_data SHALL equal feat_data.
REQ-017 ACC: each accept increments k; the accept with k==n_reg-1 SHALL move to CAPT next cycle; feat_valid gaps SHALL only stall.
REQ-018 CAPT: feat_ready=0, enc_en=0; out_data register SHALL load enc_vec at the end of CAPT; go to OUT.
REQ-019 OUT: out_valid=1, out_data stable until out_valid&out_ready; on that handshake n_done increments (wraps 0xFFFF->0) and state goes to IDLE.
REQ-020 enc_cnt SHALL equal n_reg and enc_thre SHALL equal thre_reg at all times outside IDLE; both hold their last values in IDLE.
REQ-021 enc_clr SHALL be 0 and enc_en SHALL be 0 in every state except CLR and ACC respectively.
REQ-022 sync_err SHALL set if enc_done is 1 on any ACC cycle without the final accept, or 0 on the final accept cycle.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 abort=1 in any state SHALL go to IDLE next cycle, drop out_valid, not increment n_done and not alter cfg_err/sync_err; abort SHALL have priority over start and over the OUT handshake in the same cycle.
REQ-025 start and abort together in IDLE SHALL leave the block in IDLE with no latch.
REQ-026 Minimum latency start->out_valid SHALL be n_reg+3 cycles with feat_valid held 1.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE; k=0; n_reg, thre_reg, out_data, n_done=0; feat_ready, enc_clr, enc_en, out_valid, busy, cfg_err, sync_err=0.
REQ-028 Reset deasserted mid-ACC SHALL resume from IDLE with no spurious out_valid and require a new start.

Verification
REQ-029 cfg_n=3, cfg_thre=1, three features with bit0 = 1,1,0, feat_valid=1, out_ready=1 -> enc_clr one cycle, enc_en three cycles, out_data bit0=1, out_valid 6 cycles after start, n_done=1.
REQ-030 cfg_n=4, feat_valid toggled 1,0,1,0,... -> exactly 4 enc_en pulses, feat_ready=0 in CAPT/OUT, result identical to gap-free run.
REQ-031 out_ready=0 for 10 cycles in OUT -> out_valid and out_data stable, feat_ready=0, second start ignored; out_ready=1 -> IDLE, n_done+1.
REQ-032 start with cfg_n=0 -> cfg_err=1, busy=0; next start with cfg_n=2 -> cfg_err=0, normal encode.
REQ-033 abort during ACC after 2 of 5 accepts, and abort coincident with the OUT handshake -> IDLE next cycle, out_valid=0, n_done unchanged; rst_n pulsed low mid-ACC -> all REQ-027 values immediately.
REQ-034 enc_done forced 0 on the final accept -> sync_err=1 and the result is still delivered; n_done preloaded to 0xFFFF plus one encode -> 0x0000.

Source files
------------

// File: rtl/encode_ctrl.sv
// ---------------------------------------------------------------------------
// encode_ctrl
//
// Sequences one hypervector encode. After an accepted start it clears the
// external encoder, streams cfg_n feature vectors into it, captures the
// encoder result and offers that result on a valid/ready output stream.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, abort          begin an encode (IDLE only) / return to IDLE
//   cfg_n, cfg_thre       feature count and threshold, sampled on start
//   feat_valid/ready/data feature input stream
//   enc_clr, enc_en       encoder clear strobe and accumulate enable
//   enc_cnt, enc_thre     latched count and threshold driven to encoder
//   enc_data              feature vector passed through to the encoder
//   enc_vec, enc_done     encoder result and encoder count carry
//   out_valid/ready/data  result output stream
//   busy                  high whenever the controller is not idle
//   cfg_err, sync_err     sticky error flags, cleared by an accepted start
//   n_done                count of delivered results (wraps)
// ---------------------------------------------------------------------------
`ifndef DIM
`define DIM 32
`endif

module encode_ctrl #(
   parameter int CNT_W = 8,
   parameter int DIM   = `DIM
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_n,
   input  logic [CNT_W-1:0] cfg_thre,
   input  logic             feat_valid,
   output logic             feat_ready,
   input  logic [DIM-1:0]   feat_data,
   output logic             enc_clr,
   output logic             enc_en,
   output logic [CNT_W-1:0] enc_cnt,
   output logic [CNT_W-1:0] enc_thre,
   output logic [DIM-1:0]   enc_data,
   input  logic [DIM-1:0]   enc_vec,
   input  logic             enc_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIM-1:0]   out_data,
   output logic             busy,
   output logic             cfg_err,
   output logic             sync_err,
   output logic [15:0]      n_done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      ACC  = 3'd2,
      CAPT = 3'd3,
      OUT  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] k_q, k_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] thre_q, thre_d;
   logic [DIM-1:0]   out_data_q, out_data_d;
   logic [15:0]      n_done_q, n_done_d;
   logic             cfg_err_q, cfg_err_d;
   logic             sync_err_q, sync_err_d;

   logic             accept;
   logic             last_acc;

   // Outputs decode directly from state so they are glitch-free relative to
   // the state register and are all zero while reset is asserted.
   assign feat_ready = (state_q == ACC);
   assign accept     = feat_valid & feat_ready;
   assign last_acc   = accept & (k_q == (n_q - 1'b1));
   assign enc_en     = accept;
   assign enc_clr    = (state_q == CLR);
   assign enc_cnt    = n_q;
   assign enc_thre   = thre_q;
   assign enc_data   = feat_data;
   assign out_valid  = (state_q == OUT);
   assign out_data   = out_data_q;
   assign busy       = (state_q != IDLE);
   assign cfg_err    = cfg_err_q;
   assign sync_err   = sync_err_q;
   assign n_done     = n_done_q;

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      n_d        = n_q;
      thre_d     = thre_q;
      out_data_d = out_data_q;
      n_done_d   = n_done_q;
      cfg_err_d  = cfg_err_q;
      sync_err_d = sync_err_q;

      // Abort wins over everything, including start and the output
      // handshake, and leaves the error flags untouched.
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (cfg_n != '0) begin
                     n_d        = cfg_n;
                     thre_d     = cfg_thre;
                     cfg_err_d  = 1'b0;
                     sync_err_d = 1'b0;
                     state_d    = CLR;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end
            end
            CLR: begin
               k_d     = '0;
               state_d = ACC;
            end
            ACC: begin
               if (accept) begin
                  k_d = k_q + 1'b1;
                  if (last_acc) begin
                     state_d = CAPT;
                  end
               end
               // The encoder carry must coincide exactly with the final
               // accept; any disagreement means the two counters drifted.
               if (last_acc ? !enc_done : enc_done) begin
                  sync_err_d = 1'b1;
               end
            end
            CAPT: begin
               out_data_d = enc_vec;
               state_d    = OUT;
            end
            OUT: begin
               if (out_ready) begin
                  n_done_d = n_done_q + 16'd1;
                  state_d  = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         k_q        <= '0;
         n_q        <= '0;
         thre_q     <= '0;
         out_data_q <= '0;
         n_done_q   <= '0;
         cfg_err_q  <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         n_q        <= n_d;
         thre_q     <= thre_d;
         out_data_q <= out_data_d;
         n_done_q   <= n_done_d;
         cfg_err_q  <= cfg_err_d;
         sync_err_q <= sync_err_d;
      end
   end

endmodule

// File: tb/tb_encode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_encode_ctrl
//
// Drives encode_ctrl with a behavioural encoder attached. Expected result
// vectors are computed from the feature table when an encode is launched,
// pushed into a queue, and popped when the result handshake occurs.
// ---------------------------------------------------------------------------
module tb_encode_ctrl;

   localparam int CNT_W = 8;
   localparam int DIM   = 32;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] cfg_n;
   logic [CNT_W-1:0] cfg_thre;
   logic             feat_valid;
   logic             feat_ready;
   logic [DIM-1:0]   feat_data;
   logic             enc_clr;
   logic             enc_en;
   logic [CNT_W-1:0] enc_cnt;
   logic [CNT_W-1:0] enc_thre;
   logic [DIM-1:0]   enc_data;
   logic [DIM-1:0]   enc_vec;
   logic             enc_done;
   logic             out_valid;
   logic             out_ready;
   logic [DIM-1:0]   out_data;
   logic             busy;
   logic             cfg_err;
   logic             sync_err;
   logic [15:0]      n_done;

   encode_ctrl #(.CNT_W(CNT_W), .DIM(DIM)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_n      (cfg_n),
      .cfg_thre   (cfg_thre),
      .feat_valid (feat_valid),
      .feat_ready (feat_ready),
      .feat_data  (feat_data),
      .enc_clr    (enc_clr),
      .enc_en     (enc_en),
      .enc_cnt    (enc_cnt),
      .enc_thre   (enc_thre),
      .enc_data   (enc_data),
      .enc_vec    (enc_vec),
      .enc_done   (enc_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .cfg_err    (cfg_err),
      .sync_err   (sync_err),
      .n_done     (n_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural encoder ----------------
   int acc_m;
   int bc [DIM];
   bit kill_done;

   always @(posedge clk) begin
      if (enc_clr) begin
         acc_m <= 0;
         for (int i = 0; i < DIM; i++) bc[i] <= 0;
      end else if (enc_en) begin
         acc_m <= acc_m + 1;
         for (int i = 0; i < DIM; i++) bc[i] <= bc[i] + int'(enc_data[i]);
      end
   end

   always_comb begin
      enc_vec = '0;
      for (int i = 0; i < DIM; i++) enc_vec[i] = (bc[i] > int'(enc_thre));
   end

   assign enc_done = enc_en && (acc_m == int'(enc_cnt) - 1) && !kill_done;

   // ---------------- checking ----------------
   int n_cmp;
   int n_mis;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string t);
      check_val({t, "_busy"},      busy,       0);
      check_val({t, "_feat_rdy"},  feat_ready, 0);
      check_val({t, "_enc_clr"},   enc_clr,    0);
      check_val({t, "_enc_en"},    enc_en,     0);
      check_val({t, "_out_valid"}, out_valid,  0);
      check_val({t, "_cfg_err"},   cfg_err,    0);
      check_val({t, "_sync_err"},  sync_err,   0);
      check_val({t, "_n_done"},    n_done,     0);
      check_val({t, "_out_data"},  out_data,   0);
      check_val({t, "_enc_cnt"},   enc_cnt,    0);
      check_val({t, "_enc_thre"},  enc_thre,   0);
   endtask

   // ---------------- scoreboard and stimulus ----------------
   logic [DIM-1:0] fv [16];
   logic [DIM-1:0] exp_q [$];
   logic [DIM-1:0] last_out;
   logic [15:0]    exp_ndone;

   function automatic logic [DIM-1:0] expect_vec(input int n, input int thre);
      logic [DIM-1:0] r;
      int cnt;
      r = '0;
      for (int b = 0; b < DIM; b++) begin
         cnt = 0;
         for (int i = 0; i < n; i++) cnt += int'(fv[i][b]);
         r[b] = (cnt > thre);
      end
      return r;
   endfunction

   // mode: 0 normal, 1 abort after 2 accepts, 2 abort on the output
   // handshake, 3 reset pulse after 2 accepts
   task automatic do_encode(input int n, input int thre, input bit gaps, input int stall,
                            input bit inj_start, input int mode);
      int idx, ow, lat, n_en, n_clr;
      bit done, ov, fr, hs;
      logic [DIM-1:0] first_out;
      logic [DIM-1:0] e;
      idx = 0; ow = 0; lat = -1; n_en = 0; n_clr = 0; done = 0; hs = 0;
      first_out = '0;
      if (mode == 0) exp_q.push_back(expect_vec(n, thre));
      @(negedge clk);
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         ov = out_valid;
         fr = feat_ready;
         start = (cyc == 0);
         if (cyc == 0) begin
            cfg_n = CNT_W'(n); cfg_thre = CNT_W'(thre);
         end else begin
            cfg_n = '1; cfg_thre = '1;
         end
         abort      = 1'b0;
         feat_valid = (idx < n) && (!gaps || (cyc % 2 == 0));
         feat_data  = (idx < n) ? fv[idx] : '0;
         out_ready  = ov && (ow >= stall);
         if (inj_start && ov && ow == 3) begin
            start = 1'b1; cfg_n = '0;
         end
         if (mode == 1 && fr && idx == 2) begin
            abort = 1'b1; feat_valid = 1'b0;
         end
         if (mode == 2 && ov && out_ready) abort = 1'b1;
         if (mode == 3 && fr && idx == 2) begin
            feat_valid = 1'b1;
            rst_n = 1'b0;
            #1;
            chk_reset("rst_mid");
            exp_ndone = 16'd0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               #1;
               check_val("rst_mid_no_ov", out_valid, 0);
               check_val("rst_mid_idle", busy, 0);
            end
            feat_valid = 1'b0;
            start = 1'b0;
            return;
         end
         #1;
         if (enc_en) n_en++;
         if (enc_clr) n_clr++;
         if (busy) begin
            check_val("enc_cnt", enc_cnt, n);
            check_val("enc_thre", enc_thre, thre);
         end
         if (idx == n) begin
            check_val("feat_rdy_late", feat_ready, 0);
            check_val("enc_en_late", enc_en, 0);
         end
         if (ov) begin
            if (lat < 0) begin
               lat = cyc; first_out = out_data;
            end else begin
               check_val("out_stable", out_data, first_out);
            end
            check_val("busy_out", busy, 1);
            ow++;
         end
         hs = ov && out_ready && !abort;
         if (hs) begin
            if (exp_q.size() == 0) begin
               check_val("sb_empty", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_val("sb_data", out_data, e);
            end
            last_out = out_data;
         end
         if (feat_valid && fr && !abort) idx++;
         @(posedge clk);
         if (hs || abort) done = 1'b1;
         @(negedge clk);
      end
      start = 1'b0; abort = 1'b0; feat_valid = 1'b0; out_ready = 1'b0;
      cfg_n = '0; cfg_thre = '0;
      if (!done) check_val("timeout", 0, 1);
      #1;
      if (hs) exp_ndone = exp_ndone + 16'd1;
      check_val("busy_after", busy, 0);
      check_val("ov_after", out_valid, 0);
      check_val("n_done", n_done, exp_ndone);
      if (mode == 0) begin
         $display("encode n=%0d thre=%0d gaps=%0d lat=%0d en=%0d out=0x%08h", n, thre, gaps, lat, n_en, last_out);
         check_val("en_pulses", n_en, n);
         check_val("clr_pulses", n_clr, 1);
         if (!gaps) check_val("latency", lat, n + 3);
      end else if (mode == 1) begin
         $display("abort after 2 accepts n=%0d", n);
         check_val("abort_en_pulses", n_en, 2);
      end else begin
         $display("abort on handshake n=%0d", n);
      end
   endtask

   logic [DIM-1:0] r1, r2;

   initial begin
      n_cmp = 0; n_mis = 0; exp_ndone = 16'd0; kill_done = 1'b0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_n = '0; cfg_thre = '0;
      feat_valid = 1'b1; feat_data = '0; out_ready = 1'b0;
      for (int i = 0; i < 16; i++) fv[i] = $urandom();
      @(negedge clk); @(negedge clk); #1;
      chk_reset("reset");
      $display("reset checked");
      feat_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // three features, bit0 = 1,1,0, threshold 1
      fv[0][0] = 1'b1; fv[1][0] = 1'b1; fv[2][0] = 1'b0;
      do_encode(3, 1, 1'b0, 0, 1'b0, 0);
      check_val("bit0", last_out[0], 1);

      // gap-free versus toggled valid must give the same result
      for (int i = 0; i < 4; i++) fv[i] = $urandom();
      do_encode(4, 2, 1'b0, 0, 1'b0, 0);
      r1 = last_out;
      do_encode(4, 2, 1'b1, 0, 1'b0, 0);
      r2 = last_out;
      check_val("gap_same", r2, r1);

      // output backpressure with an ignored start during OUT
      for (int i = 0; i < 3; i++) fv[i] = $urandom();
      do_encode(3, 0, 1'b0, 10, 1'b1, 0);
      check_val("ign_start_cfg_err", cfg_err, 0);

      // zero feature count
      @(negedge clk);
      start = 1'b1; cfg_n = '0; cfg_thre = 8'd1;
      @(negedge clk);
      start = 1'b0;
      #1;
      $display("start with cfg_n=0");
      check_val("cfg_err_set", cfg_err, 1);
      check_val("cfg_err_idle", busy, 0);
      do_encode(2, 0, 1'b0, 0, 1'b0, 0);
      check_val("cfg_err_clr", cfg_err, 0);

      // aborts
      do_encode(5, 1, 1'b0, 0, 1'b0, 1);
      check_val("abort_sync_err", sync_err, 0);
      do_encode(3, 1, 1'b0, 0, 1'b0, 2);

      // start and abort together in IDLE: nothing latched
      @(negedge clk);
      start = 1'b1; abort = 1'b1; cfg_n = 8'd7; cfg_thre = 8'd6;
      @(negedge clk);
      start = 1'b0; abort = 1'b0; cfg_n = '0; cfg_thre = '0;
      #1;
      $display("start with abort in IDLE");
      check_val("st_ab_busy", busy, 0);
      check_val("st_ab_cnt", enc_cnt, 3);
      check_val("st_ab_thre", enc_thre, 1);

      // reset pulse mid-ACC
      $display("reset pulse mid-ACC");
      do_encode(5, 1, 1'b0, 0, 1'b0, 3);

      // missing encoder carry on the final accept
      kill_done = 1'b1;
      do_encode(2, 0, 1'b0, 0, 1'b0, 0);
      kill_done = 1'b0;
      check_val("sync_err_set", sync_err, 1);

      // n_done wrap
      @(negedge clk);
      force dut.n_done_q = 16'hFFFF;
      #1;
      release dut.n_done_q;
      exp_ndone = 16'hFFFF;
      do_encode(1, 0, 1'b0, 0, 1'b0, 0);
      check_val("sync_err_clr", sync_err, 0);

      check_val("sb_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
